// File: rtl/crc_pkg.sv
// Shared constants and state encoding for the serial CRC append controller.
// The CRC5 datapath is only built when CRC5_MODE_EN is defined.
package crc_pkg;

  localparam int unsigned CRC16_W = 16;
  localparam int unsigned CRC5_W  = 5;
  localparam int unsigned IDX_W   = 4;

  localparam logic [15:0] POLY16    = 16'h8005;
  localparam logic [4:0]  POLY5     = 5'h05;
  localparam logic [15:0] INIT16    = 16'hFFFF;
  localparam logic [4:0]  INIT5     = 5'h1F;
  localparam logic [15:0] RESIDUE16 = 16'h800D;
  localparam logic [4:0]  RESIDUE5  = 5'h0C;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CRC     = 2'd2
  } state_t;

  // Generator polynomial for the selected mode (0 = CRC16, 1 = CRC5), zero-extended.
  function automatic logic [15:0] crc_poly(input logic sel);
    return sel ? 16'(POLY5) : POLY16;
  endfunction

  // Register seed for the selected mode, zero-extended.
  function automatic logic [15:0] crc_init(input logic sel);
    return sel ? 16'(INIT5) : INIT16;
  endfunction

  // Register value left after feeding payload plus appended complemented CRC.
  function automatic logic [15:0] crc_residue(input logic sel);
    return sel ? 16'(RESIDUE5) : RESIDUE16;
  endfunction

  // Index loaded at packet start: width minus one.
  function automatic logic [IDX_W-1:0] crc_idx_init(input logic sel);
    return sel ? IDX_W'(CRC5_W - 1) : IDX_W'(CRC16_W - 1);
  endfunction

endpackage

// File: rtl/crc_lfsr.sv
// Serial MSB-first CRC shift register; seeds to all ones on reset or clear.
module crc_lfsr #(
  parameter int unsigned          WIDTH = 16,
  parameter logic [WIDTH-1:0]     POLY  = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             d,
  input  logic             en,
  input  logic             clear,
  output logic [WIDTH-1:0] q
);

  logic fb;

  assign fb = d ^ q[WIDTH-1];

  // Shift one data bit in per enabled cycle; clear has priority over en.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '1;
    end else if (clear) begin
      q <= '1;
    end else if (en) begin
      q <= {q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : {WIDTH{1'b0}});
    end
  end

endmodule

// File: rtl/crc_append_ctrl.sv
// Serial CRC sequencer: passes payload bits through while updating the CRC,
// then appends the complemented CRC MSB first under ready/valid.
// Optional feature macro: CRC5_MODE_EN (enables the CRC5 path and crc_sel).
module crc_append_ctrl
  import crc_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  input  logic crc_sel,
  input  logic in_bit,
  input  logic in_valid,
  input  logic in_last,
  output logic in_ready,
  output logic out_bit,
  output logic out_valid,
  input  logic out_ready,
  output logic busy,
  output logic done
);

  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_init;
  logic               done_q;
  logic               start_ok;
  logic               pay_xfer;
  logic               crc_step;
  logic               crc_end;
  logic               crc_bit;
  logic [CRC16_W-1:0] crc16_q;

  assign start_ok = (state_q == IDLE) && start;
  assign pay_xfer = (state_q == PAYLOAD) && in_valid && out_ready;
  assign crc_step = (state_q == CRC) && out_ready;
  assign crc_end  = crc_step && (idx_q == '0);

  crc_lfsr #(
    .WIDTH (CRC16_W),
    .POLY  (POLY16)
  ) u_crc16 (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (in_bit),
    .en      (pay_xfer),
    .clear   (start_ok),
    .q       (crc16_q)
  );

`ifdef CRC5_MODE_EN
  logic              sel_q;
  logic [CRC5_W-1:0] crc5_q;

  crc_lfsr #(
    .WIDTH (CRC5_W),
    .POLY  (POLY5)
  ) u_crc5 (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (in_bit),
    .en      (pay_xfer),
    .clear   (start_ok),
    .q       (crc5_q)
  );

  // Mode is captured only when a packet is opened.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel_q <= 1'b0;
    end else if (start_ok) begin
      sel_q <= crc_sel;
    end
  end

  assign idx_init = crc_idx_init(crc_sel);
  assign crc_bit  = sel_q ? ~crc5_q[idx_q[2:0]] : ~crc16_q[idx_q];
`else
  logic unused_crc_sel;

  assign unused_crc_sel = crc_sel;
  assign idx_init       = crc_idx_init(1'b0);
  assign crc_bit        = ~crc16_q[idx_q];
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs; payload phase is a straight pass-through.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_bit   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        in_ready  = out_ready;
        out_valid = in_valid;
        out_bit   = in_bit;
        if (pay_xfer && in_last) state_d = CRC;
      end
      CRC: begin
        out_valid = 1'b1;
        out_bit   = crc_bit;
        if (crc_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit-index down-counter for the CRC append phase; frozen while stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= IDX_W'(CRC16_W - 1);
    end else if (start_ok) begin
      idx_q <= idx_init;
    end else if (crc_step) begin
      idx_q <= idx_q - IDX_W'(1);
    end
  end

  // One-cycle completion pulse after the final CRC bit transfers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= crc_end;
    end
  end

  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule

// File: doc/crc_append_ctrl.md
# crc_append_ctrl

Serial CRC sequencer for the bitstream encoder. It passes payload bits through unchanged while updating a CRC16 or CRC5 LFSR. After the last payload bit it appends the complemented CRC, MSB first, under a ready/valid handshake. It sits between the packet assembler (upstream) and the bit-stuffing stage (downstream), and owns the CRC register and its bit-index down-counter.

## Interface
- Parameters: none. Polynomials and widths are fixed constants in the package.
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that opens a packet; honoured only in IDLE
- crc_sel  in  1  sampled with start: 0 = CRC16, 1 = CRC5
- in_bit  in  1  payload bit
- in_valid  in  1  in_bit is valid
- in_last  in  1  qualifies the final payload bit of the packet
- in_ready  out  1  controller accepts the payload bit
- out_bit  out  1  serial output bit
- out_valid  out  1  out_bit is valid
- out_ready  in  1  downstream accepts out_bit; may stall at any cycle
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse after the final CRC bit transfers

## Operation
- States: IDLE, PAYLOAD, CRC.
- IDLE:
  - in_ready=0, out_valid=0, out_bit=0.
  - start → PAYLOAD. In the same edge: latch crc_sel, load the CRC register with all ones (16'hFFFF or 5'h1F), load the index with width−1 (15 or 4).
- PAYLOAD (pass-through):
  - out_bit=in_bit, out_valid=in_valid, in_ready=out_ready. These are combinational paths.
  - A transfer is in_valid && out_ready.
  - On each transfer: fb = in_bit ^ crc[msb]; crc ← {crc[msb-1:0],0} ^ (fb ? POLY : 0).
  - Transfer with in_last=1 → CRC.
- CRC:
  - in_ready=0, out_valid=1, out_bit = ~crc[idx].
  - Each out_ready cycle decrements idx.
  - Transfer at idx==0 → IDLE and done=1 next cycle.
- Arithmetic: CRC5 uses only the low 5 register bits, POLY5=5'h05. CRC16 uses POLY16=16'h8005. Upper bits are don't-care in CRC5 mode.
- start outside IDLE is ignored. crc_sel is ignored except when sampled with start.
- in_last without in_valid has no effect.
- Every packet contains at least one payload bit; upstream guarantees this.
- out_ready low freezes the CRC register, idx and state.
- Async reset at any point:
  - Returns to IDLE immediately.
  - All outputs go to 0.
  - The CRC register resets to all ones and idx to 15.
  - The packet in flight is abandoned; no done pulse.

## Timing
- Reset values: in_ready=0, out_bit=0, out_valid=0, busy=0, done=0.
- Payload latency is 0 cycles (combinational).
- The first CRC bit is valid the cycle after the in_last transfer.
- CRC phase with no stalls: 16 (or 5) cycles.
- done is registered: high exactly one cycle, coincident with IDLE.
- start is accepted in the done cycle, so packets can run back to back with no gap.
- busy rises the cycle after start.

## Configuration
- Macro: CRC5_MODE_EN.
- Defined: crc_sel is honoured and the 5-bit path, POLY5 and index load of 4 are built.
- Undefined:
  - crc_sel is ignored; every packet uses CRC16.
  - The CRC5 logic is not synthesised.
  - The port still exists.

## Structure
- Package crc_pkg:
  - state enum (IDLE, PAYLOAD, CRC)
  - POLY16=16'h8005, POLY5=5'h05
  - INIT16=16'hFFFF, INIT5=5'h1F
  - RESIDUE16=16'h800D, RESIDUE5=5'h0C
- Sub-module crc_lfsr:
  - Parameters WIDTH and POLY.
  - Inputs d, en, clear.
  - Output Q, which loads all ones on reset or clear.
  - crc_append_ctrl instantiates the 16-bit one, plus the 5-bit one under CRC5_MODE_EN, and owns the FSM and the index down-counter.

## Test plan
- CRC16, single payload bit 0, out_ready=1 → out stream 0, then 1000_0000_0000_0100 (~16'h7FFB = 16'h8004, MSB first); done 17 cycles after the in_last transfer.
- CRC5, single payload bit 1 → CRC bits 00001 (~5'h1E). Single bit 0 → 00100 (~5'h1B).
- Random 8–1024-bit payloads in both modes, fed through a reference model → emitted CRC matches. Re-running payload+CRC through a fresh LFSR yields RESIDUE16 / RESIDUE5.
- Random out_ready stalls during both PAYLOAD and CRC → output stream identical to the unstalled run; no bit duplicated or dropped.
- start while busy, plus in_valid pulses while in IDLE → ignored, with no state or CRC change. start in the done cycle → next packet begins with no gap.
- reset_n asserted mid-CRC (idx=7) → outputs 0 immediately, no done pulse. The next packet produces the correct CRC.
